rsa_modexp_ctrl: RTL and testbench
==================================

// Module: rsa_modexp_ctrl
// PURPOSE
//  Sequencer directly upstream of the Montgomery multiplier (mmm_unit).
//  Computes RESULT = P^E mod M by square-and-multiply (MSB first), issuing every MMM op.
//  Drives the multiplier's control strobes and A/B/M operands, and writes back its R output.
//  Owns the acc/xbar working registers; sits between the RSA peripheral register file and mmm_unit.
// PARAMETERS
//  WIDTH  4  operand width; must equal the WIDTH of the attached mmm_unit
// PORTS
//  clk        in   1      clock
//  rstb       in   1      asynchronous active-low reset
//  ena        in   1      global enable; low freezes all state (FSM, counters, regs)
//  clear      in   1      synchronous abort: back to IDLE next cycle
//  start      in   1      begin exponentiation; sampled only in IDLE
//  P          in   WIDTH  plaintext/base, < M
//  E          in   WIDTH  exponent
//  M          in   WIDTH  modulus, odd
//  CONST      in   WIDTH  2^(2*WIDTH) mod M
//  busy       out  1      high from cycle after accepted start until DONE
//  done       out  1      one-cycle pulse; RESULT valid from this cycle
//  RESULT     out  WIDTH  last result; held until next done
//  mmm_ena    out  1      to mmm_unit ena
//  mmm_clear  out  1      to mmm_unit clear
//  mmm_ld_a   out  1      to mmm_unit ld_a
//  mmm_ld_r   out  1      to mmm_unit ld_r
//  mmm_lock   out  1      to mmm_unit lock
//  mmm_a      out  WIDTH  to mmm_unit A
//  mmm_b      out  WIDTH  to mmm_unit B
//  mmm_m      out  WIDTH  to mmm_unit M (latched M)
//  mmm_r      in   WIDTH  from mmm_unit R
// BEHAVIOUR
//  - Reset: all outputs 0; acc, xbar, latched operands 0; FSM IDLE.
//  - start in IDLE (ena=1): latch P,E,M,CONST. Inputs may then change freely.
//  - One MMM op = T = WIDTH+3 cycles:
//    - LOAD: ld_a=1.
//    - COMPUTE: WIDTH cycles.
//    - STORE: ld_r=1.
//    - WB: lock=1; capture mmm_r into the op's destination.
//    - mmm_ena=1 in all four phases. mmm_a/mmm_b stay stable from LOAD through STORE.
//  - Op order (a,b -> dest):
//    - XB: (P,CONST)->xbar.
//    - ONE: (1,CONST)->acc.
//    - Per exponent bit, MSB first: SQ (acc,acc)->acc; if bit=1, MUL (acc,xbar)->acc.
//    - FIN: (acc,1)->RESULT.
//  - FSM: IDLE -> XB -> ONE -> LOOP{SQ[,MUL]} -> FIN -> DONE -> IDLE.
//    - Bit counter runs WIDTH-1 down to 0; E shift register moves left after each bit.
//  - done is high exactly in the DONE cycle, with busy=0 in that cycle.
//    - Latency from start edge to done = ops*T + 1, where ops = 3 + bits_processed + popcount(E).
//  - start while busy: ignored. start and clear in the same IDLE cycle: clear wins; nothing latched.
//  - clear while busy: IDLE next cycle; mmm_clear=1 for one cycle; RESULT unchanged; no done.
//  - ena=0: every register holds, mmm_ena=0, other strobes 0. Resuming continues bit-exact.
//  - rstb low mid-op: immediate return to reset values; no done.
//  - E=0: RESULT = 1.
//  - M even, P>=M or wrong CONST: RESULT undefined; FSM still terminates with the same latency.
// CONFIGURATION
//  RSA_SKIP_LEADING_ZEROS_EN defined:
//   - After ONE, skip exponent bits above the highest set bit; bits_processed = index(MSB one)+1.
//   - E=0 gives bits_processed=0: straight to FIN.
//  Undefined: bits_processed = WIDTH always. RESULT is identical either way; only latency differs.
// TESTING (WIDTH=8, T=11)
//  1. M=0x8F, CONST=0x2A, P=0x05, E=0x07, start
//     -> done after 155 cycles (100 with _EN); RESULT=0x2F.
//  2. Same operands, E=0x00
//     -> RESULT=0x01 after 122 cycles (34 with _EN).
//  3. Test 1 with ena=0 for 20 cycles mid-COMPUTE
//     -> done 20 cycles later; RESULT=0x2F.
//  4. Test 1, clear at cycle 50
//     -> busy=0 next cycle; mmm_clear pulses once; no done; RESULT keeps previous value.
//     -> A new start then yields 0x2F.
//  5. rstb low at cycle 40 of test 1
//     -> all outputs 0 immediately; a fresh run gives 0x2F.
//  6. start pulsed again while busy in test 1
//     -> ignored; single done; RESULT=0x2F.
//     -> Check mmm_ld_a/mmm_ld_r pulse counts = ops (14 without _EN).

Source files
------------

// File: rtl/rsa_modexp_ctrl_if.sv
// rsa_modexp_ctrl_if: host-side and mmm_unit-side signals of the modexp sequencer.
interface rsa_modexp_ctrl_if #(parameter int WIDTH = 4);
  logic ena, clear, start, busy, done;
  logic mmm_ena, mmm_clear, mmm_ld_a, mmm_ld_r, mmm_lock;
  logic [WIDTH-1:0] P, E, M, CONST, RESULT;
  logic [WIDTH-1:0] mmm_a, mmm_b, mmm_m, mmm_r;
  modport slave (
    input  ena, clear, start, P, E, M, CONST, mmm_r,
    output busy, done, RESULT, mmm_ena, mmm_clear, mmm_ld_a, mmm_ld_r, mmm_lock, mmm_a, mmm_b, mmm_m
  );
  modport master (
    output ena, clear, start, P, E, M, CONST, mmm_r,
    input  busy, done, RESULT, mmm_ena, mmm_clear, mmm_ld_a, mmm_ld_r, mmm_lock, mmm_a, mmm_b, mmm_m
  );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: MSB-first square-and-multiply sequencer driving a Montgomery multiplier.
// Optional RSA_SKIP_LEADING_ZEROS_EN skips exponent bits above the highest set bit.
module rsa_modexp_ctrl #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rstb,
  rsa_modexp_ctrl_if.slave bus
);
  localparam int PW = $clog2(WIDTH + 3);
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PH_ST = PW'(WIDTH + 1);
  localparam logic [PW-1:0] PH_WB = PW'(WIDTH + 2);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  typedef enum logic [2:0] {S_IDLE, S_XB, S_ONE, S_SQ, S_MUL, S_FIN, S_DONE} st_t;
  st_t r_st, w_nst;
  logic [PW-1:0] r_ph, w_nph;
  logic [BW-1:0] r_bit, w_bit0;
  logic [WIDTH-1:0] r_e, r_m, r_c, r_acc, r_xbar, r_res, r_a, r_b;
  logic [WIDTH-1:0] w_e0, w_acc, w_a, w_b;
  logic r_busy, r_done, r_clr, r_ld_a, r_ld_r, r_lock;
  logic w_go, w_op, w_wb, w_nop, w_load, w_last, w_bit_end, w_skip;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
  logic r_ez;
  logic [BW-1:0] w_msb;
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < WIDTH; i++) if (bus.E[i]) w_msb = BW'(i);
  end
  // pre-align E so its highest set bit sits at the top of the shift register
  assign w_bit0 = w_msb;
  assign w_e0 = bus.E << (BW'(WIDTH - 1) - w_msb);
  assign w_skip = r_ez;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) r_ez <= 1'b0;
    else if (bus.ena && w_go) r_ez <= bus.E == '0;
`else
  assign w_bit0 = BW'(WIDTH - 1);
  assign w_e0 = bus.E;
  assign w_skip = 1'b0;
`endif
  assign w_go = r_st == S_IDLE && bus.start && !bus.clear;
  assign w_op = r_st != S_IDLE && r_st != S_DONE;
  assign w_wb = w_op && r_ph == PH_WB;
  assign w_last = r_bit == '0;
  assign w_bit_end = w_wb && ((r_st == S_SQ && !r_e[WIDTH-1]) || r_st == S_MUL);
  assign w_nop = w_nst != S_IDLE && w_nst != S_DONE;
  assign w_load = w_nop && w_nph == '0;
  assign w_acc = (w_wb && (r_st == S_ONE || r_st == S_SQ || r_st == S_MUL)) ? bus.mmm_r : r_acc;
  always_comb begin
    w_nst = r_st;
    w_nph = r_ph;
    if (bus.clear) begin
      w_nst = S_IDLE;
      w_nph = '0;
    end else begin
      case (r_st)
        S_IDLE: w_nst = bus.start ? S_XB : S_IDLE;
        S_DONE: w_nst = S_IDLE;
        default: begin
          w_nph = w_wb ? '0 : r_ph + 1'b1;
          if (w_wb)
            case (r_st)
              S_XB:    w_nst = S_ONE;
              S_ONE:   w_nst = w_skip ? S_FIN : S_SQ;
              S_SQ:    w_nst = r_e[WIDTH-1] ? S_MUL : (w_last ? S_FIN : S_SQ);
              S_MUL:   w_nst = w_last ? S_FIN : S_SQ;
              default: w_nst = S_DONE;
            endcase
        end
      endcase
    end
  end
  // operands for the op being entered; acc forwarding covers back-to-back ops
  always_comb begin
    w_a = w_acc;
    w_b = ONE_V;
    case (w_nst)
      S_XB:    begin w_a = bus.P; w_b = bus.CONST; end
      S_ONE:   begin w_a = ONE_V; w_b = r_c; end
      S_SQ:    w_b = w_acc;
      S_MUL:   w_b = r_xbar;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      r_st <= S_IDLE;
      r_ph <= '0;
      r_bit <= '0;
      r_e <= '0;
      r_m <= '0;
      r_c <= '0;
      r_acc <= '0;
      r_xbar <= '0;
      r_res <= '0;
      r_a <= '0;
      r_b <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_clr <= 1'b0;
      r_ld_a <= 1'b0;
      r_ld_r <= 1'b0;
      r_lock <= 1'b0;
    end else if (bus.ena) begin
      r_st <= w_nst;
      r_ph <= w_nph;
      r_busy <= w_nop;
      r_done <= w_nst == S_DONE;
      r_ld_a <= w_load;
      r_ld_r <= w_nop && w_nph == PH_ST;
      r_lock <= w_nop && w_nph == PH_WB;
      r_clr <= bus.clear && w_op;
      if (w_load) begin
        r_a <= w_a;
        r_b <= w_b;
      end
      if (w_go) begin
        r_e <= w_e0;
        r_bit <= w_bit0;
        r_m <= bus.M;
        r_c <= bus.CONST;
      end
      if (!bus.clear) begin
        r_acc <= w_acc;
        if (w_wb && r_st == S_XB) r_xbar <= bus.mmm_r;
        if (w_wb && r_st == S_FIN) r_res <= bus.mmm_r;
        if (w_bit_end) begin
          r_e <= r_e << 1;
          r_bit <= r_bit - 1'b1;
        end
      end
    end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.RESULT = r_res;
  assign bus.mmm_ena = r_busy & bus.ena;
  assign bus.mmm_clear = r_clr & bus.ena;
  assign bus.mmm_ld_a = r_ld_a & bus.ena;
  assign bus.mmm_ld_r = r_ld_r & bus.ena;
  assign bus.mmm_lock = r_lock & bus.ena;
  assign bus.mmm_a = r_a;
  assign bus.mmm_b = r_b;
  assign bus.mmm_m = r_m;
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// tb_rsa_modexp_ctrl: directed runs against a cycle-count/modpow model with a Montgomery multiplier stand-in.
module tb_rsa_modexp_ctrl;
  localparam int W = 8;
  localparam int T = W + 3;
  localparam int NO = -1000;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
  localparam int L1 = 100, L2 = 34, L3 = 120, OPS7 = 9;
`else
  localparam int L1 = 155, L2 = 122, L3 = 175, OPS7 = 14;
`endif
  logic clk = 1'b0;
  logic rstb = 1'b0;
  int errs = 0;
  int checks = 0;
  int m_st = 0;
  int m_left = 0;
  int m_ops = 0;
  int m_pend = 0;
  int m_res = 0;
  bit m_mclr = 1'b0;
  int n_lda = 0;
  int n_ldr = 0;
  int n_clrp = 0;
  rsa_modexp_ctrl_if #(.WIDTH(W)) bus ();
  rsa_modexp_ctrl #(.WIDTH(W)) dut (.clk(clk), .rstb(rstb), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction
  function automatic int modpow(input int p, input int e, input int m);
    longint r = 1;
    for (int k = 0; k < e; k++) r = (r * p) % m;
    return int'(r);
  endfunction
  function automatic int ops_of(input logic [W-1:0] e);
    int bits = W;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
    bits = 0;
    for (int i = 0; i < W; i++) if (e[i]) bits = i + 1;
`endif
    return 3 + bits + $countones(e);
  endfunction
  // multiplier stand-in: result registered at STORE, visible during WB
  always @(posedge clk or negedge rstb)
    if (!rstb) bus.mmm_r <= '0;
    else if (bus.mmm_ena && bus.mmm_ld_r) bus.mmm_r <= mont(bus.mmm_a, bus.mmm_b, bus.mmm_m);
  initial forever begin
    @(negedge clk);
    if (!rstb) begin
      m_st = 0;
      m_res = 0;
      m_mclr = 1'b0;
      n_lda = 0;
      n_ldr = 0;
    end
    chk("busy", bus.busy, m_st == 1);
    chk("done", bus.done, m_st == 2);
    chk("RESULT", bus.RESULT, m_res);
    chk("mmm_ena", bus.mmm_ena, m_st == 1 && bus.ena);
    chk("mmm_clear", bus.mmm_clear, m_mclr && bus.ena);
    n_lda += int'(bus.mmm_ld_a);
    n_ldr += int'(bus.mmm_ld_r);
    n_clrp += int'(bus.mmm_clear);
    if (m_st == 2) begin
      chk("ld_a count", n_lda, m_ops);
      chk("ld_r count", n_ldr, m_ops);
    end
    if (rstb && bus.ena) begin
      m_mclr = bus.clear && m_st == 1;
      if (bus.clear) m_st = 0;
      else if (m_st == 0 && bus.start) begin
        m_st = 1;
        m_ops = ops_of(bus.E);
        m_left = m_ops * T;
        m_pend = modpow(int'(bus.P), int'(bus.E), int'(bus.M));
        n_lda = 0;
        n_ldr = 0;
      end else if (m_st == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_st = 2;
          m_res = m_pend;
        end
      end else if (m_st == 2) m_st = 0;
    end
  end
  task automatic chk_zero(input string nm);
    chk({nm, " busy"}, bus.busy, 0);
    chk({nm, " done"}, bus.done, 0);
    chk({nm, " RESULT"}, bus.RESULT, 0);
    chk({nm, " strobes"}, {bus.mmm_ena, bus.mmm_clear, bus.mmm_ld_a, bus.mmm_ld_r, bus.mmm_lock}, 0);
    chk({nm, " operands"}, {bus.mmm_a, bus.mmm_b, bus.mmm_m}, 0);
  endtask
  task automatic run(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] m, input int lim,
                     input int pause_at, input int clr_at, input int dup_at, input int rst_at, output int lat);
    lat = -1;
    @(posedge clk); #1;
    bus.P = p;
    bus.E = e;
    bus.M = m;
    bus.CONST = W'((1 << (2 * W)) % int'(m));
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= lim; n++) begin
      if (bus.done) begin
        lat = n;
        break;
      end
      if (n == pause_at) bus.ena = 1'b0;
      if (n == pause_at + 20) bus.ena = 1'b1;
      if (n == dup_at) bus.start = 1'b1;
      if (n == dup_at + 1) bus.start = 1'b0;
      if (n == clr_at) bus.clear = 1'b1;
      if (n == clr_at + 1) begin
        bus.clear = 1'b0;
        chk("busy after clear", bus.busy, 0);
        chk("mmm_clear after clear", bus.mmm_clear, 1);
      end
      if (n == rst_at) begin
        rstb = 1'b0;
        #1;
        chk_zero("mid-run reset");
      end
      if (n == rst_at + 3) rstb = 1'b1;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    int lat;
    int c0;
    logic [W-1:0] vp[5] = '{8'h7E, 8'h02, 8'h8E, 8'h00, 8'h05};
    logic [W-1:0] ve[5] = '{8'h80, 8'hFF, 8'h01, 8'h05, 8'h0C};
    logic [W-1:0] vm[5] = '{8'h8F, 8'hFB, 8'h8F, 8'h8F, 8'h61};
    bus.ena = 1'b1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.P = '0;
    bus.E = '0;
    bus.M = '0;
    bus.CONST = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rstb = 1'b1;
    run(8'h05, 8'h07, 8'h8F, 3000, NO, NO, NO, NO, lat);
    chk("t1 latency", lat, L1);
    chk("t1 RESULT", bus.RESULT, 8'h2F);
    run(8'h05, 8'h07, 8'h8F, 3000, 5, NO, NO, NO, lat);
    chk("t3 latency", lat, L3);
    chk("t3 RESULT", bus.RESULT, 8'h2F);
    run(8'h05, 8'h00, 8'h8F, 3000, NO, NO, NO, NO, lat);
    chk("t2 latency", lat, L2);
    chk("t2 RESULT", bus.RESULT, 8'h01);
    c0 = n_clrp;
    run(8'h05, 8'h07, 8'h8F, 80, NO, 50, NO, NO, lat);
    chk("t4 no done", lat, -1);
    chk("t4 RESULT kept", bus.RESULT, 8'h01);
    chk("t4 mmm_clear pulses", n_clrp - c0, 1);
    run(8'h05, 8'h07, 8'h8F, 3000, NO, NO, NO, NO, lat);
    chk("t4 rerun RESULT", bus.RESULT, 8'h2F);
    run(8'h05, 8'h07, 8'h8F, 80, NO, NO, NO, 40, lat);
    chk("t5 no done", lat, -1);
    run(8'h05, 8'h07, 8'h8F, 3000, NO, NO, NO, NO, lat);
    chk("t5 rerun latency", lat, L1);
    chk("t5 rerun RESULT", bus.RESULT, 8'h2F);
    run(8'h05, 8'h07, 8'h8F, 3000, NO, NO, 30, NO, lat);
    chk("t6 latency", lat, L1);
    chk("t6 RESULT", bus.RESULT, 8'h2F);
    chk("t6 ld_a pulses", n_lda, OPS7);
    chk("t6 ld_r pulses", n_ldr, OPS7);
    for (int k = 0; k < 5; k++) begin
      run(vp[k], ve[k], vm[k], 3000, NO, NO, NO, NO, lat);
      chk("vector latency", lat, ops_of(ve[k]) * T + 1);
      chk("vector RESULT", bus.RESULT, modpow(int'(vp[k]), int'(ve[k]), int'(vm[k])));
    end
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
